smoldvi_tmds_decode: RTL

- Receive-side counterpart of the TMDS encode/serialise path.
- Takes raw 10-bit parallel words from a pixel-rate deserialiser at arbitrary bit alignment, and finds symbol alignment by searching for runs of TMDS control tokens.
- Decodes each aligned symbol back to {den, c[1:0], d[7:0]}.
- One instance per TMDS data channel, in the pixel clock domain, feeding capture/loopback logic.

---
 rtl/smoldvi_tmds_decode_if.sv | 14 +
 rtl/smoldvi_tmds_decode.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/smoldvi_tmds_decode_if.sv
// Signal bundle between a TMDS deserialiser lane and its symbol decoder.
interface smoldvi_tmds_decode_if;
  logic [9:0] sym_in;
  logic       resync;
  logic       locked;
  logic [3:0] slip;
  logic       den;
  logic [1:0] c;
  logic [7:0] d;

  // Master drives raw words and resync; slave is the decoder.
  modport master (output sym_in, resync, input locked, slip, den, c, d);
  modport slave  (input sym_in, resync, output locked, slip, den, c, d);
endinterface

// File: rtl/smoldvi_tmds_decode.sv
// Per-channel TMDS receive decoder: finds symbol alignment from control-token
// runs, then decodes aligned symbols to {den, c, d}.
module smoldvi_tmds_decode #(
  parameter int unsigned LOCK_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  smoldvi_tmds_decode_if.slave  bus
);

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned SLIP_W = 4;
  localparam int unsigned RUN_W  = $clog2(LOCK_RUN + 1);
  localparam int unsigned IDLE_W = $clog2(SEARCH_WINDOW);

  localparam logic [RUN_W-1:0]  RUN_LIM  = RUN_W'(LOCK_RUN);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(SEARCH_WINDOW - 1);
  localparam logic [SLIP_W-1:0] SLIP_MAX = SLIP_W'(9);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_nxt;
  logic [SYM_W-1:0]    prev_q;
  logic [SYM_W-1:0]    q_q;
  logic [SLIP_W-1:0]   slip_q, slip_nxt;
  logic [RUN_W-1:0]    run_q, run_nxt;
  logic [IDLE_W-1:0]   idle_q, idle_nxt;
  logic                den_q, den_nxt;
  logic [1:0]          c_q, c_nxt;
  logic [7:0]          d_q, d_nxt;

  logic [2*SYM_W-1:0]  window_c;
  logic [SYM_W-1:0]    aligned_c;
  logic                is_tok_c;
  logic [1:0]          tok_val_c;
  logic [7:0]          t_c;
  logic [7:0]          dec_c;
  logic [RUN_W-1:0]    run_inc_c;
  logic [IDLE_W-1:0]   idle_inc_c;
  logic [SLIP_W-1:0]   slip_adv_c;

  // Two-word window so any bit offset 0..9 can be extracted.
  always_comb begin
    window_c  = {bus.sym_in, prev_q};
    aligned_c = SYM_W'(window_c >> slip_q);
  end

  // Control-token recognition and data-symbol decode of the stage-1 word.
  always_comb begin
    is_tok_c  = 1'b1;
    tok_val_c = 2'b00;
    dec_c     = 8'h00;
    unique case (q_q)
      10'b1101010100: tok_val_c = 2'b00;
      10'b0010101011: tok_val_c = 2'b01;
      10'b0101010100: tok_val_c = 2'b10;
      10'b1010101011: tok_val_c = 2'b11;
      default:        is_tok_c  = 1'b0;
    endcase
    t_c      = q_q[9] ? ~q_q[7:0] : q_q[7:0];
    dec_c[0] = t_c[0];
    for (int i = 1; i < 8; i++) begin
      dec_c[i] = q_q[8] ? (t_c[i] ^ t_c[i-1]) : ~(t_c[i] ^ t_c[i-1]);
    end
  end

  // Alignment FSM, run/idle counters and output-stage next values.
  always_comb begin
    state_nxt = state_q;
    slip_nxt  = slip_q;
    den_nxt   = den_q;
    c_nxt     = c_q;
    d_nxt     = d_q;

    run_inc_c  = is_tok_c ? ((run_q == RUN_LIM) ? run_q : run_q + RUN_W'(1))
                          : '0;
    idle_inc_c = is_tok_c ? '0 : idle_q + IDLE_W'(1);
    slip_adv_c = (slip_q == SLIP_MAX) ? '0 : slip_q + SLIP_W'(1);
    run_nxt    = run_inc_c;
    idle_nxt   = idle_inc_c;

    if (bus.resync) begin
      // Re-search at the same slip; overrides any lock or slip event this cycle.
      state_nxt = SEARCH;
      run_nxt   = '0;
      idle_nxt  = '0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (run_inc_c == RUN_LIM) begin
            state_nxt = LOCKED;
          end else if (idle_inc_c == IDLE_LIM) begin
            slip_nxt = slip_adv_c;
            run_nxt  = '0;
            idle_nxt = '0;
          end
        end
        LOCKED: begin
          if (idle_inc_c == IDLE_LIM) begin
            state_nxt = SEARCH;
            slip_nxt  = slip_adv_c;
            run_nxt   = '0;
            idle_nxt  = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end

    // Outputs follow the lock state taking effect at this edge.
    if (state_nxt != LOCKED) begin
      den_nxt = 1'b0;
      c_nxt   = 2'b00;
      d_nxt   = 8'h00;
    end else if (is_tok_c) begin
      den_nxt = 1'b0;
      c_nxt   = tok_val_c;
    end else begin
      den_nxt = 1'b1;
      d_nxt   = dec_c;
    end
  end

  // Pipeline, FSM and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      prev_q  <= '0;
      q_q     <= '0;
      slip_q  <= '0;
      run_q   <= '0;
      idle_q  <= '0;
      den_q   <= 1'b0;
      c_q     <= 2'b00;
      d_q     <= 8'h00;
    end else begin
      state_q <= state_nxt;
      prev_q  <= bus.sym_in;
      q_q     <= aligned_c;
      slip_q  <= slip_nxt;
      run_q   <= run_nxt;
      idle_q  <= idle_nxt;
      den_q   <= den_nxt;
      c_q     <= c_nxt;
      d_q     <= d_nxt;
    end
  end

  assign bus.locked = (state_q == LOCKED);
  assign bus.slip   = slip_q;
  assign bus.den    = den_q;
  assign bus.c      = c_q;
  assign bus.d      = d_q;

endmodule
